// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file write arbiter:
//   AW / DW      register index width and data width
//   NREG         number of architectural registers (2**AW)
//   arb_state_t  starvation FSM states (IDLE, WAIT, DRAIN)
//   mdu_wr_t     one buffered MDU write: destination index + result data
// ---------------------------------------------------------------------------
package rf_arb_pkg;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } mdu_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles every non-clock signal of the arbiter.
//   WB side   : WBregWrite, WBwriteReg, WBresult
//   MDU side  : mduIssue, mduIssueReg, mduValid/mduReady, mduDest, mduResult
//   ID side   : idRs, idRt -> idStall
//   RF side   : rfRegWrite, rfWriteReg, rfWriteData
// master = the pipeline/MDU/register-file environment, slave = the arbiter.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if;
    import rf_arb_pkg::*;

    logic          WBregWrite;
    logic [AW-1:0] WBwriteReg;
    logic [DW-1:0] WBresult;
    logic          mduIssue;
    logic [AW-1:0] mduIssueReg;
    logic          mduValid;
    logic          mduReady;
    logic [AW-1:0] mduDest;
    logic [DW-1:0] mduResult;
    logic [AW-1:0] idRs;
    logic [AW-1:0] idRt;
    logic          idStall;
    logic          rfRegWrite;
    logic [AW-1:0] rfWriteReg;
    logic [DW-1:0] rfWriteData;

    modport master (
        output WBregWrite, WBwriteReg, WBresult,
        output mduIssue, mduIssueReg,
        output mduValid, mduDest, mduResult,
        output idRs, idRt,
        input  mduReady, idStall,
        input  rfRegWrite, rfWriteReg, rfWriteData
    );

    modport slave (
        input  WBregWrite, WBwriteReg, WBresult,
        input  mduIssue, mduIssueReg,
        input  mduValid, mduDest, mduResult,
        input  idRs, idRt,
        output mduReady, idStall,
        output rfRegWrite, rfWriteReg, rfWriteData
    );
endinterface

// File: rtl/rf_arb_fifo.sv
// ---------------------------------------------------------------------------
// rf_arb_fifo
// Synchronous FIFO of mdu_wr_t entries buffering MDU results until the
// register-file write port is free.
//   clk, rst  clock, asynchronous active-high reset (flushes pointers/count)
//   i_push    write i_wdata at the edge (caller guarantees !o_full)
//   i_pop     drop the head at the edge (caller guarantees !o_empty)
//   o_head    current head entry (valid when !o_empty)
//   o_full    count == DEPTH
//   o_empty   count == 0
// ---------------------------------------------------------------------------
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  mdu_wr_t i_wdata,
    input  logic    i_pop,
    output mdu_wr_t o_head,
    output logic    o_full,
    output logic    o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    mdu_wr_t       r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Owns the register file's single write port. WB has fixed priority and is
// never stalled; MDU results queue in a small FIFO and take the port on any
// cycle WB does not write. A busy scoreboard of outstanding MDU destinations
// stalls ID on RAW hazards, and a starvation FSM forces ID stalls (bubbles
// that eventually free WB) when the FIFO head has been blocked too long.
//   clk, rst  clock, asynchronous active-high reset
//   bus       rf_write_arbiter_if.slave (WB, MDU, ID and RF signals)
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
)(
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    mdu_wr_t           w_head;
    mdu_wr_t           w_wdata;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_blocked;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [SW-1:0]     r_cnt;
    logic [SW-1:0]     w_cnt_nxt;

    assign w_wdata   = '{dest: bus.mduDest, data: bus.mduResult};
    assign w_push    = bus.mduValid & ~w_full;
    assign w_pop     = ~bus.WBregWrite & ~w_empty;
    assign w_blocked = bus.WBregWrite & ~w_empty;

    rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready depends only on stored occupancy, never on mduValid.
    assign bus.mduReady = ~rst & ~w_full;

    // Grant mux: WB first, then FIFO head. A reg-0 target still consumes
    // the grant (and pops the head) but never asserts the write enable.
    always_comb begin
        bus.rfRegWrite  = 1'b0;
        bus.rfWriteReg  = '0;
        bus.rfWriteData = '0;
        if (!rst) begin
            if (bus.WBregWrite) begin
                bus.rfRegWrite  = (bus.WBwriteReg != '0);
                bus.rfWriteReg  = bus.WBwriteReg;
                bus.rfWriteData = bus.WBresult;
            end else if (!w_empty) begin
                bus.rfRegWrite  = (w_head.dest != '0);
                bus.rfWriteReg  = w_head.dest;
                bus.rfWriteData = w_head.data;
            end
        end
    end

    // Scoreboard: OR-ing the set mask after the clear makes an issue to a
    // register whose previous result drains this cycle leave it busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.mduIssue) begin
            w_set[bus.mduIssueReg] = 1'b1;
        end
        if (w_pop) begin
            w_clr[w_head.dest] = 1'b1;
        end
        w_set[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.idStall = ~rst & (((bus.idRs != '0) & r_busy[bus.idRs]) |
                                 ((bus.idRt != '0) & r_busy[bus.idRt]) |
                                 (r_state == DRAIN));

    // Starvation FSM: r_cnt counts consecutive cycles the head lost to WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_blocked) begin
                    w_cnt_nxt   = SW'(1);
                    w_state_nxt = (STARVE_LIMIT <= 1) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (w_pop) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_blocked) begin
                    w_cnt_nxt = r_cnt + SW'(1);
                    if (r_cnt + SW'(1) >= SW'(STARVE_LIMIT)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
endmodule
